// File: rtl/seven_seg_pkg.sv
`default_nettype none
//==============================================================================
// Module      : seven_seg_pkg
// Description : Shared segment patterns, conversion FSM states and the BCD to
//               7-segment decoder used by the scanned display controller.
// Revision    : 1.0 - initial release
//==============================================================================
package seven_seg_pkg;

    // Active-low gfedcba cathode patterns
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Binary to BCD converter sequencing
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } conv_state_t;

    // Non-decimal nibbles fall back to the '0' glyph
    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        logic [6:0] v_seg;
        case (bcd)
            4'd0:    v_seg = SEG_0;
            4'd1:    v_seg = SEG_1;
            4'd2:    v_seg = SEG_2;
            4'd3:    v_seg = SEG_3;
            4'd4:    v_seg = SEG_4;
            4'd5:    v_seg = SEG_5;
            4'd6:    v_seg = SEG_6;
            4'd7:    v_seg = SEG_7;
            4'd8:    v_seg = SEG_8;
            4'd9:    v_seg = SEG_9;
            default: v_seg = SEG_0;
        endcase
        return v_seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
//==============================================================================
// Module      : bin2bcd_seq
// Description : Sequential double-dabble converter with a valid/ready load
//               port. One shift/add-3 step per cycle; result and overflow
//               flag are presented together with a one-cycle done strobe.
// Revision    : 1.0 - initial release
//==============================================================================
module bin2bcd_seq
    import seven_seg_pkg::*;
#(
    parameter int VAL_W      = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [VAL_W-1:0]        value,
    input  logic                    value_vld,
    output logic                    value_rdy,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    ovf,
    output logic                    done
);

    localparam int                 c_bcd_w     = 4 * NUM_DIGITS;
    localparam int                 c_step_w    = $clog2(VAL_W + 1);
    localparam logic [c_step_w-1:0] c_last_step = c_step_w'(VAL_W - 1);
    localparam logic [63:0]        c_limit     = 64'(10 ** NUM_DIGITS);

    conv_state_t           r_state;
    conv_state_t           w_next;
    logic                  r_rdy;
    logic [VAL_W-1:0]      r_bin;
    logic [c_bcd_w-1:0]    r_work;
    logic [c_bcd_w-1:0]    w_adj;
    logic [c_step_w-1:0]   r_step;
    logic                  r_ovf_next;
    logic                  w_accept;
    logic                  w_ovf_cap;

    // Add 3 to every nibble that is 5 or more before the next left shift.
    // Only the displayed digits are kept: digits above them cannot feed back
    // into lower ones, so the result is value mod 10**NUM_DIGITS.
    function automatic logic [c_bcd_w-1:0] dd_adjust(input logic [c_bcd_w-1:0] b);
        logic [c_bcd_w-1:0] v_adj;
        v_adj = b;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v_adj[4*i +: 4] > 4'd4) begin
                v_adj[4*i +: 4] = v_adj[4*i +: 4] + 4'd3;
            end
        end
        return v_adj;
    endfunction

    assign w_accept  = value_vld && r_rdy;
    assign w_ovf_cap = (64'(value) >= c_limit);
    assign w_adj     = dd_adjust(r_work);

    // Conversion state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode: capture, VAL_W shift steps, one load cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = CONV;
            CONV:    if (r_step == c_last_step) w_next = LOAD;
            LOAD:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Ready is registered so it stays low throughout reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdy <= 1'b0;
        end else begin
            r_rdy <= (w_next == IDLE);
        end
    end

    // Capture and double-dabble shift datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bin      <= '0;
            r_work     <= '0;
            r_step     <= '0;
            r_ovf_next <= 1'b0;
        end else if (r_state == IDLE && w_accept) begin
            r_bin      <= value;
            r_work     <= '0;
            r_step     <= '0;
            r_ovf_next <= w_ovf_cap;
        end else if (r_state == CONV) begin
            r_work <= c_bcd_w'({w_adj, r_bin[VAL_W-1]});
            r_bin  <= r_bin << 1;
            r_step <= r_step + c_step_w'(1);
        end
    end

    assign value_rdy = r_rdy;
    assign bcd       = r_work;
    assign ovf       = r_ovf_next;
    assign done      = (r_state == LOAD);

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : seven_seg_scan_ctrl
// Description : Multiplexed NUM_DIGITS 7-segment driver. Sequential BCD
//               conversion, leading-zero blanking, overflow dashes and
//               16-level PWM brightness; anode/seg are registered outputs.
// Revision    : 1.0 - initial release
//==============================================================================
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int VAL_W      = 14,
    parameter int SCAN_DIV   = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [VAL_W-1:0]      value,
    input  logic                  value_vld,
    output logic                  value_rdy,
    input  logic                  blank_lz,
    input  logic [3:0]            bright,
    output logic                  ovf,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [6:0]            seg
);

    localparam int                 c_cnt_w    = $clog2(SCAN_DIV + 1);
    localparam int                 c_idx_w    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_cnt_w-1:0] c_pre_last = c_cnt_w'(SCAN_DIV - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] w_bcd;
    logic                    w_ovf_next;
    logic                    w_done;
    logic [4*NUM_DIGITS-1:0] r_bcd;
    logic                    r_ovf;
    logic [c_cnt_w-1:0]      r_pre;
    logic [c_idx_w-1:0]      r_idx;
    logic [c_cnt_w-1:0]      r_thr;
    logic [c_cnt_w-1:0]      w_thr;
    logic                    w_lit;
    logic [3:0]              w_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_lz;
    logic [NUM_DIGITS-1:0]   w_anode;
    logic [6:0]              w_seg;

    bin2bcd_seq #(
        .VAL_W      (VAL_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk       (clk),
        .rst_n     (rst_n),
        .value     (value),
        .value_vld (value_vld),
        .value_rdy (value_rdy),
        .bcd       (w_bcd),
        .ovf       (w_ovf_next),
        .done      (w_done)
    );

    // Display value and overflow flag change together on the done strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bcd <= '0;
            r_ovf <= 1'b0;
        end else if (w_done) begin
            r_bcd <= w_bcd;
            r_ovf <= w_ovf_next;
        end
    end

    assign ovf = r_ovf;

    // On-time threshold for the coming slot: (bright+1)/16 of SCAN_DIV
    assign w_thr = c_cnt_w'(((32'(bright) + 32'd1) * 32'(SCAN_DIV)) >> 4);

    // Slot prescaler, digit index and per-slot brightness threshold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_idx <= '0;
            r_thr <= '0;
        end else if (r_pre == c_pre_last) begin
            r_pre <= '0;
            r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + c_idx_w'(1);
            r_thr <= w_thr;
        end else begin
            r_pre <= r_pre + c_cnt_w'(1);
        end
    end

    assign w_lit = (r_pre < r_thr);

    // Digit 0 is the leftmost (most significant) digit and drives the top anode bit
    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
            assign w_digit[g]                = r_bcd[4*(NUM_DIGITS-1-g) +: 4];
            assign w_anode[NUM_DIGITS-1-g]   = ~(w_lit && (r_idx == c_idx_w'(g)));
        end
    endgenerate

    // w_lz[i] is set when digit i and every digit left of it are zero
    always_comb begin
        logic v_run;
        w_lz  = '0;
        v_run = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            v_run   = v_run && (w_digit[i] == 4'd0);
            w_lz[i] = v_run;
        end
    end

    // Pattern priority: overflow dashes, then leading-zero blanking, then digit
    always_comb begin
        w_seg = seg_decode(w_digit[r_idx]);
        if (r_ovf) begin
            w_seg = SEG_DASH;
        end else if (blank_lz && w_lz[r_idx] && (r_idx != c_idx_last)) begin
            w_seg = SEG_BLANK;
        end
    end

    // Registered pin drivers, dark during reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            anode <= '1;
            seg   <= SEG_BLANK;
        end else begin
            anode <= w_anode;
            seg   <= w_seg;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : tb_seven_seg_scan_ctrl
// Description : Self-checking bench for seven_seg_scan_ctrl with a decimal
//               arithmetic reference model and randomized loads.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_seven_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int VW = 14;
    localparam int SD = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [VW-1:0] value = '0;
    logic          value_vld = 1'b0;
    logic          value_rdy;
    logic          blank_lz = 1'b0;
    logic [3:0]    bright = 4'd15;
    logic          ovf;
    logic [ND-1:0] anode;
    logic [6:0]    seg;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .VAL_W      (VW),
        .SCAN_DIV   (SD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .value     (value),
        .value_vld (value_vld),
        .value_rdy (value_rdy),
        .blank_lz  (blank_lz),
        .bright    (bright),
        .ovf       (ovf),
        .anode     (anode),
        .seg       (seg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pow10(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1000000;
        endcase
    endfunction

    // Expected glyph for display position idx (0 = leftmost) from the decimal value
    function automatic logic [6:0] exp_seg(input int val, input bit ovf_m, input bit blz, input int idx);
        int hi;
        if (ovf_m) return 7'b0111111;
        hi = val / pow10(ND - 1 - idx);
        if (blz && hi == 0 && idx != ND - 1) return 7'h7F;
        return pat(hi % 10);
    endfunction

    // Reference model: m_k counts clocks since reset release
    int            m_k;
    int            m_val;
    bit            m_ovf;
    int            m_busy;
    bit            m_rdy;
    int            m_pend;
    int            m_thr;
    logic [ND-1:0] m_anode;
    logic [6:0]    m_seg;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_k     <= 0;
            m_val   <= 0;
            m_ovf   <= 1'b0;
            m_busy  <= 0;
            m_rdy   <= 1'b0;
            m_pend  <= 0;
            m_thr   <= 0;
            m_anode <= '1;
            m_seg   <= 7'h7F;
        end else begin
            m_k     <= m_k + 1;
            m_seg   <= exp_seg(m_val, m_ovf, blank_lz, (m_k / SD) % ND);
            m_anode <= ((m_k % SD) < m_thr) ? ~(4'b1000 >> ((m_k / SD) % ND)) : 4'hF;
            if ((m_k % SD) == SD - 1) m_thr <= ((int'(bright) + 1) * SD) >> 4;
            if (m_busy == 0) begin
                if (m_rdy && value_vld) begin
                    m_busy <= VW + 1;
                    m_rdy  <= 1'b0;
                    m_pend <= int'(value);
                end else begin
                    m_rdy <= 1'b1;
                end
            end else begin
                m_busy <= m_busy - 1;
                m_rdy  <= (m_busy == 1);
                if (m_busy == 1) begin
                    m_val <= m_pend;
                    m_ovf <= (m_pend >= pow10(ND));
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("anode", 32'(anode), 32'(m_anode));
            check("seg",   32'(seg),   32'(m_seg));
            check("rdy",   32'(value_rdy), 32'(m_rdy));
            check("ovf",   32'(ovf),   32'(m_ovf));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer a value and hold it until the handshake completes
    task automatic send(input int v);
        int guard = 0;
        value     = VW'(v);
        value_vld = 1'b1;
        forever begin
            @(negedge clk);
            if (value_rdy === 1'b1) break;
            guard++;
            if (guard > 200) begin
                check("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        value_vld = 1'b0;
    endtask

    // Count busy cycles until ready returns
    task automatic wait_idle(output int low);
        low = 0;
        forever begin
            @(negedge clk);
            if (value_rdy === 1'b1) break;
            low++;
            if (low > 200) begin
                check("idle_timeout", 32'd0, 32'd1);
                break;
            end
        end
        #1;
    endtask

    task automatic load(input int v);
        int low;
        send(v);
        wait_idle(low);
        check("rdy_low_cycles", 32'(low), 32'(VW + 1));
    endtask

    // Over one full 64-cycle scan, total lit cycles = ND * (bright+1)
    task automatic duty(input int b);
        int cnt = 0;
        bright = 4'(b);
        tick(80);
        repeat (ND * SD) begin
            @(negedge clk);
            if (anode !== 4'hF) cnt++;
        end
        #1;
        check("duty_cycles", 32'(cnt), 32'(ND * (b + 1)));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int low;

        // Reset held for three edges
        rst_n = 1'b0;
        tick(1);
        chk_en = 1'b1;
        tick(2);
        check("rst_anode", 32'(anode), 32'h0000000F);
        check("rst_seg",   32'(seg),   32'h0000007F);
        check("rst_rdy",   32'(value_rdy), 32'd0);
        check("rst_ovf",   32'(ovf),   32'd0);
        rst_n = 1'b1;
        tick(1);
        check("rdy_after_rst", 32'(value_rdy), 32'd1);
        tick(70);

        // 1234 at full brightness
        load(1234);
        tick(70);

        // Leading-zero blanking
        blank_lz = 1'b1;
        load(7);
        tick(70);
        load(0);
        tick(70);
        blank_lz = 1'b0;

        // Overflow boundary
        load(10000);
        tick(2);
        check("ovf_10000", 32'(ovf), 32'd1);
        tick(68);
        load(9999);
        tick(2);
        check("ovf_9999", 32'(ovf), 32'd0);
        tick(68);

        // Brightness extremes
        duty(0);
        duty(7);
        duty(15);

        // A value offered while busy is ignored
        send(1234);
        value     = VW'(42);
        value_vld = 1'b1;
        tick(5);
        value_vld = 1'b0;
        wait_idle(low);
        tick(70);

        // Reset in the middle of a conversion
        send(5555);
        tick(5);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("rdy_after_midrst", 32'(value_rdy), 32'd1);
        tick(70);

        // Randomized loads, blanking and brightness
        for (int it = 0; it < 40; it++) begin
            blank_lz = 1'($urandom_range(0, 1));
            bright   = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       v = int'($urandom_range(9990, 10010));
                1:       v = int'($urandom_range(0, 99));
                default: v = int'($urandom_range(0, 16383));
            endcase
            if ($urandom_range(0, 3) == 0) begin
                send(v);
                value     = VW'($urandom_range(0, 16383));
                value_vld = 1'b1;
                tick(int'($urandom_range(1, 10)));
                value_vld = 1'b0;
                wait_idle(low);
            end else begin
                load(v);
            end
            tick(int'($urandom_range(0, 80)));
        end

        tick(5);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
